// File: rtl/butterfly_ctrl_if.sv
// rtl/butterfly_ctrl_if.sv - control/address bundle between the FFT sequencer and its datapath
interface butterfly_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] s;
    logic       load;
    logic       en_real;
    logic       en_imag;
    logic [2:0] stage;
    logic [3:0] bfly_idx;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [3:0] tw_addr;
    logic       wb_valid;
    logic [4:0] wb_addr_a;
    logic [4:0] wb_addr_b;

    modport master (
        input  start,
        output busy, done, s, load, en_real, en_imag, stage, bfly_idx,
               addr_a, addr_b, tw_addr, wb_valid, wb_addr_a, wb_addr_b
    );

    modport slave (
        output start,
        input  busy, done, s, load, en_real, en_imag, stage, bfly_idx,
               addr_a, addr_b, tw_addr, wb_valid, wb_addr_a, wb_addr_b
    );
endinterface

// File: rtl/butterfly_ctrl.sv
// rtl/butterfly_ctrl.sv - 32-point radix-2 FFT sequencer: 5 stages x 16 butterflies, 4 cycles each
module butterfly_ctrl (
    input  logic              clk,
    input  logic              reset,
    butterfly_ctrl_if.master  bus
);

    typedef enum logic [2:0] {IDLE, C0, C1, C2, CAPT, GAP, FLUSH} state_t;

    state_t     state, state_nxt;
    logic [2:0] stage, stage_nxt;
    logic [3:0] bfly_idx, bfly_nxt;
    logic       wb_valid;
    logic [4:0] wb_addr_a, wb_addr_b;

    logic [1:0] s_c;
    logic       load_c;
    logic       en_c;

    logic [4:0] half, half_mask, grp_base, addr_a, addr_b;
    logic [3:0] pos, grp, tw_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage     <= 3'd0;
            bfly_idx  <= 4'd0;
            wb_valid  <= 1'b0;
            wb_addr_a <= 5'd0;
            wb_addr_b <= 5'd0;
        end else begin
            stage    <= stage_nxt;
            bfly_idx <= bfly_nxt;
            wb_valid <= (state == CAPT);
            if (state == CAPT) begin
                wb_addr_a <= addr_a;
                wb_addr_b <= addr_b;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        bfly_nxt  = bfly_idx;
        s_c       = 2'd3;
        load_c    = 1'b0;
        en_c      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = C0;
                    stage_nxt = 3'd0;
                    bfly_nxt  = 4'd0;
                end
            end
            C0: begin
                s_c       = 2'd0;
                load_c    = 1'b1;
                state_nxt = C1;
            end
            C1: begin
                s_c       = 2'd1;
                state_nxt = C2;
            end
            C2: begin
                s_c       = 2'd2;
                state_nxt = CAPT;
            end
            CAPT: begin
                en_c = 1'b1;
                if (bfly_idx != 4'd15) begin
                    bfly_nxt  = bfly_idx + 4'd1;
                    state_nxt = C0;
                end else if (stage != 3'd4) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = FLUSH;
                end
            end
            // Bubble lets the final write-back of a stage retire before the next stage reads.
            GAP: begin
                stage_nxt = stage + 3'd1;
                bfly_nxt  = 4'd0;
                state_nxt = C0;
            end
            FLUSH: begin
                stage_nxt = 3'd0;
                bfly_nxt  = 4'd0;
                state_nxt = IDLE;
            end
            default: begin
                stage_nxt = 3'd0;
                bfly_nxt  = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Butterfly span halves each stage; the group base is grp*2*half expressed as a shift.
    always_comb begin
        half      = 5'd16 >> stage;
        half_mask = half - 5'd1;
        pos       = bfly_idx & half_mask[3:0];
        grp       = bfly_idx >> (3'd4 - stage);
        grp_base  = {1'b0, grp} << (3'd5 - stage);
        addr_a    = grp_base | {1'b0, pos};
        addr_b    = addr_a + half;
        tw_addr   = pos << stage;
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FLUSH);
    assign bus.s         = s_c;
    assign bus.load      = load_c;
    assign bus.en_real   = en_c;
    assign bus.en_imag   = en_c;
    assign bus.stage     = stage;
    assign bus.bfly_idx  = bfly_idx;
    assign bus.addr_a    = addr_a;
    assign bus.addr_b    = addr_b;
    assign bus.tw_addr   = tw_addr;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_addr_a = wb_addr_a;
    assign bus.wb_addr_b = wb_addr_b;

endmodule

// File: doc/butterfly_ctrl.md
BUTTERFLY_CTRL -- requirements
Module: butterfly_ctrl

Interface
REQ-001 Parameters: none; 32-point transform, 5 stages, 16 butterflies per stage, all fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  in  1  request to run a full 5-stage sequence; sampled only in IDLE.
REQ-005 busy  out  1  high from the first sequencing cycle through the FLUSH cycle.
REQ-006 done  out  1  one-cycle pulse in the FLUSH cycle.
REQ-007 s  out  2  operand-select code to the butterfly datapath units.
REQ-008 load  out  1  MAC load: 1 = acc <= x1*x2; 0 = acc <= acc + x1*x2.
REQ-009 en_real, en_imag  out  1 each  output-register capture enables to the butterfly units.
REQ-010 stage  out  3  current stage, 0..4.
REQ-011 bfly_idx  out  4  current butterfly within the stage, 0..15.
REQ-012 addr_a, addr_b  out  5 each  data-memory read addresses of operands a and b.
REQ-013 tw_addr  out  4  twiddle ROM address.
REQ-014 wb_valid  out  1  write-back strobe for the results of the previous butterfly.
REQ-015 wb_addr_a, wb_addr_b  out  5 each  write-back addresses, registered.

Function
REQ-016 FSM states: IDLE, C0, C1, C2, CAPT, GAP, FLUSH; one state per cycle, no stalls.
REQ-017 IDLE: start=1 -> C0 with stage=0, bfly_idx=0; start=0 -> stay in IDLE.
REQ-018 Per-butterfly sequence C0 -> C1 -> C2 -> CAPT, 4 cycles.
REQ-019 C0: s=0, load=1. C1: s=1, load=0. C2: s=2, load=0. CAPT: s=3, load=0, en_real=en_imag=1.
REQ-020 In IDLE, GAP and FLUSH: s=3, load=0, en_real=en_imag=0.
REQ-021 CAPT with bfly_idx<15 -> C0; bfly_idx increments by 1.
REQ-022 CAPT with bfly_idx=15 and stage<4 -> GAP; GAP -> C0 with stage incremented and bfly_idx=0.
REQ-023 GAP is a one-cycle bubble. It guarantees the last write-back of a stage lands before the next stage reads memory.
REQ-024 CAPT with bfly_idx=15 and stage=4 -> FLUSH; FLUSH -> IDLE with stage and bfly_idx cleared to 0.
REQ-025 Address generation is combinational from stage and bfly_idx, and is held constant from C0 through CAPT:
  - half = 16 >> stage
  - pos = bfly_idx mod half
  - grp = bfly_idx / half
  - addr_a = grp*2*half + pos
  - addr_b = addr_a + half
  - tw_addr = pos << stage, truncated to 4 bits
REQ-026 wb_valid SHALL be a register of (state==CAPT). It is high in the cycle after each CAPT: the next C0, GAP, or FLUSH.
REQ-027 wb_addr_a and wb_addr_b SHALL load addr_a and addr_b on every CAPT edge, and hold otherwise.
REQ-028 busy SHALL be 1 in states C0, C1, C2, CAPT, GAP and FLUSH, and 0 in IDLE.
REQ-029 done SHALL equal (state==FLUSH).
REQ-030 start while busy is ignored; it does not queue a second run.
REQ-031 Cycle budget: start sampled at edge 0 -> C0 in cycle 1; 80 butterflies plus 4 GAPs occupy cycles 1..324; FLUSH in cycle 325; IDLE in cycle 326.

Reset
REQ-032 On reset assertion, the block SHALL immediately enter IDLE and force the following, regardless of the state it was in:
  - stage=0, bfly_idx=0, wb_addr_a=0, wb_addr_b=0
  - wb_valid=0, busy=0, done=0
  - s=3, load=0, en_real=0, en_imag=0
REQ-033 After reset deasserts, the block SHALL take no action until start=1 is sampled in IDLE.

Verification
REQ-034 Single start pulse: busy high for exactly 325 cycles, done pulses once at cycle 325, exactly 80 wb_valid pulses, and exactly 4 GAP cycles in which en_real=0.
REQ-035 Per-butterfly check: the s/load/en pattern is 0/1/0, 1/0/0, 2/0/0, 3/0/1 on four consecutive cycles for every butterfly.
REQ-036 Address checks, each written as (stage, bfly_idx) -> (addr_a, addr_b, tw_addr):
  - (0,5) -> (5, 21, 5)
  - (2,5) -> (9, 13, 4)
  - (4,5) -> (10, 11, 0)
  - (1,15) -> (23, 31, 14)
REQ-037 Write-back check: wb_addr_a/wb_addr_b seen with each wb_valid equal the addr_a/addr_b of the preceding CAPT; the last pulse carries (30, 31) and coincides with done.
REQ-038 start held high for 400 cycles: exactly one run until FLUSH, then a new run begins with C0 in cycle 327.
REQ-039 Reset asserted mid-run (stage 2, state C1): outputs return to their reset values asynchronously, with no done pulse; a subsequent start runs the full 325-cycle sequence.
